reg_dump: RTL and testbench



---
 rtl/reg_dump.sv | 95 +++++++++
 tb/tb_reg_dump.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Debug read-out engine: walks the GPR read port and streams a header word
// followed by every register value on a valid/ready word stream.
module reg_dump #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // state | meaning
  // IDLE  | no dump in progress, waiting for start
  // HDR   | header word {A5, seq} presented on the stream
  // REG   | register idx presented on the stream
  typedef enum logic [1:0] {IDLE, HDR, REG} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [7:0]        seq;
  logic              hs;

  assign hs      = out_valid & out_ready;
  assign idx_nxt = idx + 1'b1;
  assign busy    = (state != IDLE);

  // rd_addr always points at the word that the next handshake will load.
  always_comb begin
    rd_addr = '0;
    if (state == REG && idx != LAST_IDX)
      rd_addr = idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      seq       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= HDR;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= DATA_W'({8'hA5, seq});
            out_last  <= 1'b0;
          end
        end
        HDR: begin
          if (hs) begin
            state    <= REG;
            idx      <= '0;
            out_data <= rd_data;
            out_last <= (NUM_REGS == 1);
          end
        end
        REG: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              seq       <= seq + 8'd1;
              done      <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              out_data <= rd_data;
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: expected beats are queued when a dump is
// requested and compared as the stream hands them over.
module tb_reg_dump;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W:0]   sb_q [$];
  logic [7:0]        exp_seq = 8'd0;
  int                ready_mode = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  reg_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  assign rd_data = gpr[rd_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // out_ready driver: changes just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // stream monitor: handshakes and stall stability, sampled on falling edges
  initial begin
    logic              stall_prev;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;
    logic [ADDR_W-1:0] stall_addr;
    logic [DATA_W:0]   exp_w;
    stall_prev = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    stall_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(stall_data));
          check("stall_last", 32'(out_last), 32'(stall_last));
          check("stall_addr", 32'(rd_addr), 32'(stall_addr));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            exp_w = sb_q.pop_front();
            check("beat_data", 32'(out_data), 32'(exp_w[DATA_W-1:0]));
            check("beat_last", 32'(out_last), 32'(exp_w[DATA_W]));
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
        stall_addr = rd_addr;
      end
    end
  end

  task automatic push_expected(input bit wr);
    logic [DATA_W-1:0] exp_r [NUM_REGS];
    for (int i = 0; i < NUM_REGS; i++) exp_r[i] = gpr[i];
    if (wr) exp_r[6] = 16'hBEEF;
    sb_q.push_back({1'b0, DATA_W'({8'hA5, exp_seq})});
    for (int i = 0; i < NUM_REGS; i++)
      sb_q.push_back({1'(i == NUM_REGS - 1), exp_r[i]});
  endtask

  task automatic do_dump(input bit poke, input bit wr, input int exp_busy);
    int                beats;
    int                busy_cyc;
    bit                got_done;
    logic [DATA_W-1:0] saved0;
    logic [DATA_W-1:0] saved6;
    beats    = 0;
    busy_cyc = 0;
    got_done = 1'b0;
    saved0   = gpr[0];
    saved6   = gpr[6];
    push_expected(wr);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) got_done = 1'b1;
      start = poke && (beats == 2 || beats == 7);
      if (wr && beats == 3) begin
        gpr[6] = 16'hBEEF;
        gpr[0] = 16'hDEAD;
      end
      if (out_valid && out_ready) beats++;
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("beat_count", 32'(beats), 32'(NUM_REGS + 1));
    if (exp_busy > 0) check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    check("busy_at_done", 32'(busy), 32'd0);
    check("valid_at_done", 32'(out_valid), 32'd0);
    check("last_at_done", 32'(out_last), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    if (got_done) exp_seq = exp_seq + 8'd1;
    if (wr) begin
      gpr[0] = saved0;
      gpr[6] = saved6;
    end
  endtask

  task automatic reset_mid_dump();
    int beats;
    beats = 0;
    push_expected(1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (beats == 4) break;
      if (out_valid && out_ready) beats++;
    end
    check("rst_beat_reached", 32'(beats), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    sb_q.delete();
    exp_seq = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) gpr[i] = DATA_W'(16'h1000 + i);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_dump(1'b0, 1'b0, 9);

    // start pulses while busy must be dropped, not queued
    do_dump(1'b1, 1'b0, 9);
    repeat (4) @(negedge clk);
    check("no_queued_start", 32'(busy), 32'd0);
    check("no_queued_valid", 32'(out_valid), 32'd0);

    ready_mode = 1;
    for (int n = 0; n < 4; n++) do_dump(1'b0, 1'b0, 0);
    ready_mode = 0;
    repeat (2) @(negedge clk);

    do_dump(1'b0, 1'b1, 9);

    reset_mid_dump();

    // seq walks A500..A5FF and wraps back to A500 on dump 257
    for (int n = 0; n < 257; n++) do_dump(1'b0, 1'b0, 9);
    check("seq_wrapped", 32'(exp_seq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
